// File: rtl/vscale_fetch_queue_pkg.sv
// Shared constants and the fetch-queue entry layout for the vscale IF stage.
package vscale_fetch_queue_pkg;

  localparam int unsigned XPR_LEN    = 32;
  localparam int unsigned INST_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0] RV32_NOP = 32'h0000_0013;

  // One buffered fetch result: 65 bits (inst, pc, bad).
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [XPR_LEN-1:0]    pc;
    logic                  bad;
  } fq_entry_t;

  localparam int unsigned EntryW = $bits(fq_entry_t);

  function automatic logic [XPR_LEN-1:0] word_align(input logic [XPR_LEN-1:0] a);
    return {a[XPR_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/vscale_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue and imem.
interface vscale_fetch_queue_if;
  import vscale_fetch_queue_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [XPR_LEN-1:0]    addr;
  logic                  resp_valid;
  logic [INST_WIDTH-1:0] resp_data;
  logic                  resp_badmem;

  modport master (
    output req_valid, addr,
    input  req_ready, resp_valid, resp_data, resp_badmem
  );

  modport slave (
    input  req_valid, addr,
    output req_ready, resp_valid, resp_data, resp_badmem
  );

endinterface

// File: rtl/vscale_fetch_fifo.sv
// Generic synchronous FIFO with flush. A push in the flush cycle lands as the sole entry.
module vscale_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // Pointer, count and storage next-state; flush wins over a same-cycle pop.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_push = push_i && (!full_o || pop_i);
    do_pop  = pop_i && !empty_o;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = push_i ? ptr_inc('0) : '0;
      cnt_d = push_i ? CW'(1) : '0;
      if (push_i) mem_d[0] = wdata_i;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Upstream credit logic must never push into a full FIFO without a pop.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/vscale_fetch_queue.sv
// vscale IF stage: sequential imem fetch, in-order response queue, redirect flush.
module vscale_fetch_queue
  import vscale_fetch_queue_pkg::*;
#(
  parameter int unsigned        DEPTH    = 2,
  parameter logic [XPR_LEN-1:0] RESET_PC = 32'h200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  redirect,
  input  logic [XPR_LEN-1:0]    redirect_pc,
  input  logic                  deq_ready,
  vscale_fetch_queue_if.master  imem,
  output logic [INST_WIDTH-1:0] inst_DX,
  output logic [XPR_LEN-1:0]    PC_DX,
  output logic                  imem_wait,
  output logic                  imem_badmem_e
);

  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [XPR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]      live_q, live_d, drop_q, drop_d;
  logic               halted_q, halted_d;

  logic [CW-1:0]      occ, pcq_cnt, inflight;
  logic               q_empty, q_full, pcq_empty, pcq_full;
  logic               q_push, q_pop;
  fq_entry_t          q_wdata, q_head;
  logic [XPR_LEN-1:0] pc_head;
  logic               misalign, req_ok, req_fire, resp_live, resp_drop;
  logic               unused_status;

  assign unused_status = ^{q_full, pcq_full, pcq_empty, pcq_cnt};

  // Credit check, handshake decode and queue push/pop selection.
  always_comb begin
    misalign  = (redirect_pc[1:0] != 2'b00);
    // reset_n gating keeps the request low while reset is held
    req_ok    = reset_n && !halted_q && !redirect
                && (({1'b0, occ} + {1'b0, live_q}) < DepthW)
                && (({1'b0, live_q} + {1'b0, drop_q}) < DepthW);
    req_fire  = req_ok && imem.req_ready;
    resp_live = imem.resp_valid && (drop_q == '0) && !redirect;
    resp_drop = imem.resp_valid && (drop_q != '0) && !redirect;
    q_pop     = deq_ready && !q_empty && !redirect;
    q_push    = redirect ? misalign : resp_live;
    if (redirect) begin
      // misaligned target becomes a faulting entry instead of a fetch
      q_wdata.inst = RV32_NOP;
      q_wdata.pc   = redirect_pc;
      q_wdata.bad  = 1'b1;
    end else begin
      q_wdata.inst = imem.resp_data;
      q_wdata.pc   = pc_head;
      q_wdata.bad  = imem.resp_badmem;
    end
  end

  // Fetch PC, outstanding/drop counters and halt flag next-state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    halted_d   = halted_q;
    inflight   = live_q + drop_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      live_d     = '0;
      halted_d   = misalign;
      // a response arriving now belongs to the oldest request and is discarded
      if (imem.resp_valid && (inflight != '0)) inflight = inflight - CW'(1);
      drop_d = inflight;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      live_d = live_q + CW'(req_fire) - CW'(resp_live);
      if (resp_drop) drop_d = drop_q - CW'(1);
      if (resp_live && imem.resp_badmem) halted_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  vscale_fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (redirect),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occ)
  );

  // PCs of live requests, oldest first; dropped responses never touch it.
  vscale_fetch_fifo #(
    .WIDTH (XPR_LEN),
    .DEPTH (DEPTH)
  ) u_pc_q (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (redirect),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_live),
    .rdata_o (pc_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_cnt)
  );

  assign imem.req_valid = req_ok;
  assign imem.addr      = word_align(fetch_pc_q);
  assign imem_wait      = q_empty;
  assign inst_DX        = q_empty ? RV32_NOP : q_head.inst;
  assign PC_DX          = q_empty ? fetch_pc_q : q_head.pc;
  assign imem_badmem_e  = !q_empty && q_head.bad;

endmodule
